moving_average_filter: RTL and testbench

Parametrised moving-average low-pass filter for the audio/voice sample path. It replaces the fixed 16-tap, 32-bit, unsigned, block-output averager with a configurable one. Window depth, data width and signedness are parameters. Input samples are qualified by a valid strobe. A run-time mode selects sliding (one output per input) or block (one output per window) averaging, and a synchronous clear flushes the history without a full reset.

---
 rtl/moving_average_filter_if.sv | 37 +++
 rtl/moving_average_filter.sv | 125 ++++++++++++
 tb/tb_moving_average_filter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/moving_average_filter_if.sv
`default_nettype none
// ============================================================================
// Module   : moving_average_filter_if
// Purpose  : Sample/result bundle for moving_average_filter. Groups the
//            sample-side controls and the averaged-output side so the filter
//            and its producer/consumer share one connection.
// Signals  : clear         - synchronous history flush (master -> slave)
//            in_valid      - noisy_data qualifies this cycle (master -> slave)
//            noisy_data    - input sample, DATA_W bits (master -> slave)
//            block_mode    - 0 sliding, 1 block/decimated (master -> slave)
//            filtered_data - averaged sample, held between updates (slave -> master)
//            out_valid     - one-cycle strobe on filtered_data update (slave -> master)
//            window_full   - DEPTH samples accepted since reset/clear (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface moving_average_filter_if #(
  parameter int DATA_W = 32
);
  logic              clear;
  logic              in_valid;
  logic [DATA_W-1:0] noisy_data;
  logic              block_mode;
  logic [DATA_W-1:0] filtered_data;
  logic              out_valid;
  logic              window_full;

  modport master (
    output clear, in_valid, noisy_data, block_mode,
    input  filtered_data, out_valid, window_full
  );

  modport slave (
    input  clear, in_valid, noisy_data, block_mode,
    output filtered_data, out_valid, window_full
  );
endinterface
`default_nettype wire

// File: rtl/moving_average_filter.sv
`default_nettype none
// ============================================================================
// Module   : moving_average_filter
// Purpose  : Parametrised moving-average low-pass filter. Keeps a circular
//            window of the last 2^LOG2_DEPTH accepted samples and a running
//            sum; emits the window average either on every accepted sample
//            once the window is primed (sliding) or once per window (block).
// Ports    : clk   - rising-edge clock
//            reset - synchronous, active-high reset
//            bus   - moving_average_filter_if.slave (clear, in_valid,
//                    noisy_data, block_mode in; filtered_data, out_valid,
//                    window_full out)
// Params   : DATA_W     - sample/output width
//            LOG2_DEPTH - log2 of window depth (1..8)
//            SIGNED     - 1 = two's-complement samples, 0 = unsigned
// Revision : 1.0 - initial release
// ============================================================================
module moving_average_filter #(
  parameter int DATA_W     = 32,
  parameter int LOG2_DEPTH = 4,
  parameter int SIGNED     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  moving_average_filter_if.slave bus
);

  localparam int                    DEPTH    = 1 << LOG2_DEPTH;
  localparam int                    SUM_W    = DATA_W + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH-1:0] PTR_LAST = LOG2_DEPTH'(DEPTH - 1);
  localparam logic [LOG2_DEPTH-1:0] PTR_ONE  = LOG2_DEPTH'(1);

  // State
  logic [DEPTH-1:0][DATA_W-1:0] window_q,    window_d;
  logic [SUM_W-1:0]             sum_q,       sum_d;
  logic [LOG2_DEPTH-1:0]        wr_ptr_q,    wr_ptr_d;
  logic                         primed_q,    primed_d;
  logic [DATA_W-1:0]            filtered_q,  filtered_d;
  logic                         out_valid_q, out_valid_d;

  // Datapath helpers
  logic [DATA_W-1:0] oldest;
  logic [SUM_W-1:0]  oldest_ext;
  logic [SUM_W-1:0]  sample_ext;
  logic [SUM_W-1:0]  next_sum;
  logic              at_last;
  logic              emit;

  // The entry about to be overwritten is the one leaving the window.
  assign oldest = window_q[wr_ptr_q];

  generate
    if (SIGNED != 0) begin : g_sign_ext
      assign oldest_ext = {{LOG2_DEPTH{oldest[DATA_W-1]}}, oldest};
      assign sample_ext = {{LOG2_DEPTH{bus.noisy_data[DATA_W-1]}}, bus.noisy_data};
    end else begin : g_zero_ext
      assign oldest_ext = {{LOG2_DEPTH{1'b0}}, oldest};
      assign sample_ext = {{LOG2_DEPTH{1'b0}}, bus.noisy_data};
    end
  endgenerate

  // Modular add/subtract is identical for signed and unsigned operands once
  // they are extended to the exact sum width.
  assign next_sum = sum_q - oldest_ext + sample_ext;

  assign at_last = (wr_ptr_q == PTR_LAST);

  // Block mode fires once per window; sliding fires once the window has been
  // filled, including on the sample that fills it.
  assign emit = bus.block_mode ? at_last : (primed_q | at_last);

  always_comb begin
    window_d    = window_q;
    sum_d       = sum_q;
    wr_ptr_d    = wr_ptr_q;
    primed_d    = primed_q;
    filtered_d  = filtered_q;
    out_valid_d = 1'b0;

    if (bus.clear) begin
      // A sample presented together with clear is dropped.
      window_d   = '0;
      sum_d      = '0;
      wr_ptr_d   = '0;
      primed_d   = 1'b0;
      filtered_d = '0;
    end else if (bus.in_valid) begin
      window_d[wr_ptr_q] = bus.noisy_data;
      sum_d              = next_sum;
      wr_ptr_d           = wr_ptr_q + PTR_ONE;
      primed_d           = primed_q | at_last;
      if (emit) begin
        // Dividing by DEPTH and truncating to DATA_W keeps exactly the bits
        // [SUM_W-1:LOG2_DEPTH]; the arithmetic/logical distinction only
        // affects fill bits above DATA_W, which are discarded.
        filtered_d  = next_sum[SUM_W-1:LOG2_DEPTH];
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      window_q    <= '0;
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      primed_q    <= 1'b0;
      filtered_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      window_q    <= window_d;
      sum_q       <= sum_d;
      wr_ptr_q    <= wr_ptr_d;
      primed_q    <= primed_d;
      filtered_q  <= filtered_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.filtered_data = filtered_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.window_full   = primed_q;

endmodule
`default_nettype wire

// File: tb/tb_moving_average_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_moving_average_filter
// Purpose  : Self-checking bench. Drives identical stimulus into an unsigned
//            and a signed filter (DATA_W=16, DEPTH=4) and compares both with
//            a reference model that keeps the list of accepted samples and
//            averages the most recent DEPTH of them with plain arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_moving_average_filter;

  localparam int DW    = 16;
  localparam int L2    = 2;
  localparam int DEPTH = 1 << L2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  moving_average_filter_if #(.DATA_W(DW)) bus_u ();
  moving_average_filter_if #(.DATA_W(DW)) bus_s ();

  moving_average_filter #(.DATA_W(DW), .LOG2_DEPTH(L2), .SIGNED(0)) dut_u (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_u)
  );

  moving_average_filter #(.DATA_W(DW), .LOG2_DEPTH(L2), .SIGNED(1)) dut_s (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_s)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int           count;
  logic [DW-1:0] hist[$];
  logic [DW-1:0] exp_u;
  logic [DW-1:0] exp_s;
  logic          exp_ov;
  logic          exp_wf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input logic rst, input logic clr, input logic v,
                              input logic [DW-1:0] d, input logic bm);
    longint sum_u;
    longint sum_s;
    if (rst || clr) begin
      count  = 0;
      hist.delete();
      exp_u  = '0;
      exp_s  = '0;
      exp_ov = 1'b0;
      exp_wf = 1'b0;
    end else if (v) begin
      count++;
      hist.push_back(d);
      if (hist.size() > DEPTH) void'(hist.pop_front());
      exp_ov = bm ? ((count % DEPTH) == 0) : (count >= DEPTH);
      exp_wf = (count >= DEPTH);
      if (exp_ov) begin
        sum_u = 0;
        sum_s = 0;
        foreach (hist[i]) begin
          sum_u += longint'(hist[i]);
          sum_s += longint'($signed(hist[i]));
        end
        exp_u = DW'(sum_u >> L2);
        exp_s = DW'(sum_s >>> L2);
      end
    end else begin
      exp_ov = 1'b0;
    end
  endtask

  // One clock: drive inputs, let the edge happen, update model, compare.
  task automatic step(input logic rst, input logic clr, input logic v,
                      input logic [DW-1:0] d, input logic bm);
    reset            = rst;
    bus_u.clear      = clr;
    bus_s.clear      = clr;
    bus_u.in_valid   = v;
    bus_s.in_valid   = v;
    bus_u.noisy_data = d;
    bus_s.noisy_data = d;
    bus_u.block_mode = bm;
    bus_s.block_mode = bm;
    @(posedge clk);
    model_update(rst, clr, v, d, bm);
    #1;
    check_eq("fd_u", {16'h0, bus_u.filtered_data}, {16'h0, exp_u});
    check_eq("ov_u", {31'h0, bus_u.out_valid},     {31'h0, exp_ov});
    check_eq("wf_u", {31'h0, bus_u.window_full},   {31'h0, exp_wf});
    check_eq("fd_s", {16'h0, bus_s.filtered_data}, {16'h0, exp_s});
    check_eq("ov_s", {31'h0, bus_s.out_valid},     {31'h0, exp_ov});
    check_eq("wf_s", {31'h0, bus_s.window_full},   {31'h0, exp_wf});
  endtask

  task automatic feed(input logic [DW-1:0] d, input logic bm);
    step(1'b0, 1'b0, 1'b1, d, bm);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    int pulses;
    logic bm_r;

    // Reset state
    do_reset();
    do_reset();
    check_eq("rst_fd", {16'h0, bus_u.filtered_data}, 32'h0);
    check_eq("rst_wf", {31'h0, bus_u.window_full},   32'h0);

    // Sliding, unsigned: 4, 8, 12, 16, 20
    feed(16'd4, 1'b0);
    feed(16'd8, 1'b0);
    feed(16'd12, 1'b0);
    check_eq("sl_no_ov3", {31'h0, bus_u.out_valid}, 32'h0);
    feed(16'd16, 1'b0);
    check_eq("sl_ov4",  {31'h0, bus_u.out_valid},   32'h1);
    check_eq("sl_val4", {16'h0, bus_u.filtered_data}, 32'd10);
    check_eq("sl_wf4",  {31'h0, bus_u.window_full}, 32'h1);
    feed(16'd20, 1'b0);
    check_eq("sl_val5", {16'h0, bus_u.filtered_data}, 32'd14);

    // Block mode: 1..8, then sliding with 9
    do_reset();
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      feed(DW'(i), 1'b1);
      if (bus_u.out_valid) pulses++;
      if (i == 4) check_eq("blk_val4", {16'h0, bus_u.filtered_data}, 32'd2);
    end
    check_eq("blk_pulses", pulses, 32'd2);
    check_eq("blk_val8", {16'h0, bus_u.filtered_data}, 32'd6);
    feed(16'd9, 1'b0);
    check_eq("blk_sw_ov",  {31'h0, bus_u.out_valid},   32'h1);
    check_eq("blk_sw_val", {16'h0, bus_u.filtered_data}, 32'd7);

    // Signed: -1, -1, -1, -2 then 5 x4
    do_reset();
    feed(16'hFFFF, 1'b0);
    feed(16'hFFFF, 1'b0);
    feed(16'hFFFF, 1'b0);
    feed(16'hFFFE, 1'b0);
    check_eq("sgn_neg", {16'h0, bus_s.filtered_data}, 32'hFFFE);
    for (int i = 0; i < 4; i++) feed(16'd5, 1'b0);
    check_eq("sgn_pos", {16'h0, bus_s.filtered_data}, 32'd5);

    // Full scale unsigned
    do_reset();
    for (int i = 0; i < 4; i++) feed(16'hFFFF, 1'b0);
    check_eq("fs_max", {16'h0, bus_u.filtered_data}, 32'hFFFF);
    feed(16'h0000, 1'b0);
    check_eq("fs_drop", {16'h0, bus_u.filtered_data}, 32'hBFFF);

    // Gaps and clear
    do_reset();
    feed(16'd4, 1'b0);
    feed(16'd8, 1'b0);
    for (int i = 0; i < 5; i++) idle();
    feed(16'd12, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'd100, 1'b0);
    check_eq("clr_fd", {16'h0, bus_u.filtered_data}, 32'h0);
    check_eq("clr_ov", {31'h0, bus_u.out_valid},     32'h0);
    check_eq("clr_wf", {31'h0, bus_u.window_full},   32'h0);
    for (int i = 0; i < 4; i++) feed(16'd3, 1'b0);
    check_eq("clr_refill", {16'h0, bus_u.filtered_data}, 32'd3);

    // Reset mid-stream on a primed, accepted sample
    feed(16'd40, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'd80, 1'b0);
    check_eq("mrst_ov", {31'h0, bus_u.out_valid},     32'h0);
    check_eq("mrst_fd", {16'h0, bus_u.filtered_data}, 32'h0);
    check_eq("mrst_wf", {31'h0, bus_u.window_full},   32'h0);
    for (int i = 0; i < 4; i++) feed(16'd20, 1'b0);
    check_eq("mrst_refill", {16'h0, bus_u.filtered_data}, 32'd20);

    // Randomized traffic with sticky mode, occasional clear/reset and gaps
    bm_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic r_rst, r_clr, r_v;
      logic [DW-1:0] r_d;
      if ($urandom_range(0, 49) == 0) bm_r = ~bm_r;
      r_rst = ($urandom_range(0, 199) == 0);
      r_clr = ($urandom_range(0, 99) == 0);
      r_v   = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       r_d = 16'hFFFF - DW'($urandom_range(0, 3));
        1:       r_d = DW'($urandom_range(0, 7));
        default: r_d = DW'($urandom);
      endcase
      step(r_rst, r_clr, r_v, r_d, bm_r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
